// File: rtl/note_tone_gen.sv
// Key-to-note selector with input synchronisation, shared debounce, two arbitration
// modes, octave shift and an integrated square-wave tone generator.
module note_tone_gen #(
    parameter int NUM_KEYS        = 12,
    parameter int PERIOD_W        = 6,
    parameter int OCT_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 1024,
    localparam int IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                mode,
    input  logic [OCT_W-1:0]    octave,
    output logic                note_valid,
    output logic [IDX_W-1:0]    note_idx,
    output logic [PERIOD_W-1:0] note_period,
    output logic                tone
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [PERIOD_W-1:0] base_period(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (8'(idx))
            8'd0:    b = 8'd38;
            8'd1:    b = 8'd36;
            8'd2:    b = 8'd34;
            8'd3:    b = 8'd32;
            8'd4:    b = 8'd30;
            8'd5:    b = 8'd29;
            8'd6:    b = 8'd27;
            8'd7:    b = 8'd26;
            8'd8:    b = 8'd24;
            8'd9:    b = 8'd23;
            8'd10:   b = 8'd21;
            default: b = 8'd20;
        endcase
        base_period = PERIOD_W'(b);
    endfunction

    // ---------------- synchroniser and shared debounce ----------------
    logic [NUM_KEYS-1:0] s1, s2, s3, keys_db;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            cnt     <= '0;
            keys_db <= '0;
        end else begin
            s1 <= keys_raw;
            s2 <= s1;
            s3 <= s2;
            if (s2 != s3) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (s2 == s3 && cnt == CNT_LAST) begin
                keys_db <= s2;
            end
        end
    end

    // ---------------- last-pressed tracking (runs in both modes) ----------------
    logic [NUM_KEYS-1:0] keys_prev, rise;
    logic [IDX_W-1:0]    last_idx, last_next;
    logic                last_valid, last_valid_next, last_held;

    always_comb begin
        rise            = keys_db & ~keys_prev;
        last_held       = |(keys_db & (NUM_KEYS'(1) << last_idx));
        last_next       = last_idx;
        last_valid_next = last_valid;
        if (rise != '0) begin
            last_next       = lowest_idx(rise);
            last_valid_next = 1'b1;
        end else if (keys_db == '0) begin
            last_next       = '0;
            last_valid_next = 1'b0;
        end else if (!last_valid || !last_held) begin
            last_next       = lowest_idx(keys_db);
            last_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_prev  <= '0;
            last_idx   <= '0;
            last_valid <= 1'b0;
        end else begin
            keys_prev  <= keys_db;
            last_idx   <= last_next;
            last_valid <= last_valid_next;
        end
    end

    // ---------------- selection (registered outputs) ----------------
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [PERIOD_W-1:0] sel_period, shifted;
    logic                sel_changed;

    always_comb begin
        sel_valid  = |keys_db;
        sel_idx    = '0;
        sel_period = '0;
        shifted    = '0;
        if (sel_valid) begin
            sel_idx    = mode ? last_next : lowest_idx(keys_db);
            shifted    = base_period(sel_idx) >> octave;
            sel_period = (shifted == '0) ? PER_ONE : shifted;
        end
        sel_changed = (sel_idx != note_idx) || (sel_period != note_period);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_valid  <= 1'b0;
            note_idx    <= '0;
            note_period <= '0;
        end else begin
            note_valid  <= sel_valid;
            note_idx    <= sel_idx;
            note_period <= sel_period;
        end
    end

    // ---------------- tone generator ----------------
    // A new note restarts the generator on the same edge the outputs change,
    // so every note begins with a complete low half-period.
    logic [PS_W-1:0]     pre;
    logic [PERIOD_W-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst || !sel_valid || sel_changed) begin
            pre  <= '0;
            tcnt <= '0;
            tone <= 1'b0;
        end else if (pre == PS_LAST) begin
            pre <= '0;
            if (tcnt == note_period - PER_ONE) begin
                tcnt <= '0;
                tone <= ~tone;
            end else begin
                tcnt <= tcnt + PER_ONE;
            end
        end else begin
            pre <= pre + PS_W'(1);
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: expected output snapshots (with their edge number)
// are queued by the stimulus and checked by an independent monitor on output changes.
module tb_note_tone_gen;

    localparam int NK = 12;
    localparam int D  = 4;
    localparam int PS = 2;
    localparam int EW = 44;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keys_raw = '0;
    logic          mode = 1'b0;
    logic [1:0]    octave = '0;
    logic          note_valid;
    logic [3:0]    note_idx;
    logic [5:0]    note_period;
    logic          tone;

    note_tone_gen #(
        .NUM_KEYS(NK), .PERIOD_W(6), .OCT_W(2), .DEBOUNCE_CYCLES(D), .PRESCALE(PS)
    ) dut (
        .clk(clk), .rst(rst), .keys_raw(keys_raw), .mode(mode), .octave(octave),
        .note_valid(note_valid), .note_idx(note_idx), .note_period(note_period), .tone(tone)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          mon_en = 1'b0;
    logic [11:0]   prev_snap;

    logic       exp_v;
    logic [3:0] exp_i;
    logic [5:0] exp_p;
    logic       exp_tone;
    int         sel_edge, tog_count, last_edge;

    task automatic push(input int c);
        exp_q.push_back({32'(c), exp_v, exp_i, exp_p, exp_tone});
    endtask

    task automatic expect_sel(input int e, input logic v, input int i, input int p);
        exp_v     = v;
        exp_i     = 4'(i);
        exp_p     = 6'(p);
        exp_tone  = 1'b0;
        sel_edge  = e;
        tog_count = 0;
        last_edge = e;
        push(e);
    endtask

    task automatic expect_toggles(input int n);
        for (int k = 0; k < n; k++) begin
            tog_count = tog_count + 1;
            exp_tone  = ~exp_tone;
            last_edge = sel_edge + tog_count * int'(exp_p) * PS;
            push(last_edge);
        end
    endtask

    task automatic drive_after(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [11:0]   snap;
        logic [EW-1:0] head;
        if (mon_en) begin
            snap = {note_valid, note_idx, note_period, tone};
            while (exp_q.size() > 0) begin
                head = exp_q[0];
                if (int'(head[43:12]) >= cyc) break;
                exp_q.delete(0);
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event: expected v=%0d idx=%0d per=%0d tone=%0d at edge %0d, not seen by edge %0d",
                         head[11], head[10:7], head[6:1], head[0], int'(head[43:12]), cyc);
            end
            if (snap !== prev_snap) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: v=%0d idx=%0d per=%0d tone=%0d at edge %0d",
                             snap[11], snap[10:7], snap[6:1], snap[0], cyc);
                end else begin
                    head = exp_q.pop_front();
                    if (head[11:0] !== snap || int'(head[43:12]) != cyc) begin
                        n_bad++;
                        $display("FAIL output_event: got v=%0d idx=%0d per=%0d tone=%0d at edge %0d, required v=%0d idx=%0d per=%0d tone=%0d at edge %0d",
                                 snap[11], snap[10:7], snap[6:1], snap[0], cyc,
                                 head[11], head[10:7], head[6:1], head[0], int'(head[43:12]));
                    end
                end
            end
            prev_snap = snap;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_note_valid", int'(note_valid), 0);
        check("reset_note_idx", int'(note_idx), 0);
        check("reset_note_period", int'(note_period), 0);
        check("reset_tone", int'(tone), 0);
        prev_snap = {note_valid, note_idx, note_period, tone};
        mon_en = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_tone", int'(tone), 0);

        // debounce latency on A, then a short glitch that must be filtered
        keys_raw = 12'h200;
        expect_sel(cyc + 3 + D + 1, 1'b1, 9, 23);
        expect_toggles(2);
        drive_after(last_edge);
        keys_raw = 12'h201;
        repeat (3) @(negedge clk);
        keys_raw = 12'h200;
        expect_toggles(1);
        drive_after(last_edge);

        // lowest-index priority
        keys_raw = 12'h090;
        expect_sel(cyc + 8, 1'b1, 4, 30);
        expect_toggles(1);
        drive_after(last_edge);
        keys_raw = 12'h080;
        expect_sel(cyc + 8, 1'b1, 7, 26);
        expect_toggles(1);
        drive_after(last_edge);

        // last-pressed priority
        mode     = 1'b1;
        keys_raw = 12'h001;
        expect_sel(cyc + 8, 1'b1, 0, 38);
        expect_toggles(1);
        drive_after(last_edge);
        keys_raw = 12'h081;
        expect_sel(cyc + 8, 1'b1, 7, 26);
        drive_after(last_edge);
        keys_raw = 12'h001;
        expect_sel(cyc + 8, 1'b1, 0, 38);
        drive_after(last_edge);
        keys_raw = 12'h045;
        expect_sel(cyc + 8, 1'b1, 2, 34);
        drive_after(last_edge);
        keys_raw = 12'h005;
        expect_toggles(1);
        drive_after(last_edge);
        keys_raw = 12'h001;
        expect_sel(cyc + 8, 1'b1, 0, 38);
        drive_after(last_edge);

        // octave shift restarts the tone
        octave = 2'd2;
        expect_sel(cyc + 1, 1'b1, 0, 9);
        expect_toggles(1);
        drive_after(last_edge);
        octave = 2'd3;
        expect_sel(cyc + 1, 1'b1, 0, 4);
        expect_toggles(3);
        drive_after(last_edge);

        // reset during an active tone, then full debounce latency again
        rst = 1'b1;
        expect_sel(cyc + 1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_sel(cyc + 8, 1'b1, 0, 4);
        expect_toggles(2);
        drive_after(last_edge);

        // release everything
        keys_raw = '0;
        expect_sel(cyc + 8, 1'b0, 0, 0);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d expected events outstanding, required 0", exp_q.size());
            exp_q.delete(0);
        end
        repeat (20) @(negedge clk);
        check("final_note_valid", int'(note_valid), 0);
        check("final_tone", int'(tone), 0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
